// File: rtl/qoi_rgb444_decoder_if.sv
// Byte-in / pixel-out handshake bundle for the QOI-style RGB444 decoder.
// The decoder uses the slave modport; the byte source / pixel sink side uses master.
interface qoi_rgb444_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        pix_ready;

  modport master (
    output in_valid, in_data, pix_ready,
    input  in_ready, pix_valid, pix_data
  );

  modport slave (
    input  in_valid, in_data, pix_ready,
    output in_ready, pix_valid, pix_data
  );
endinterface

// File: rtl/qoi_rgb444_decoder.sv
// Rebuilds RGB444 pixels from the INDEX/DIFF/FULL/RUN op byte stream.
// Optional macro QOI444_DEC_IDX_CHECK_EN: flag INDEX ops that point past the filled palette.
module qoi_rgb444_decoder #(
  parameter int PAL_DEPTH = 64,
  parameter int RUN_MAX   = 63
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  qoi_rgb444_decoder_if.slave   bus,
  output logic [15:0]           pix_count,
  output logic                  err
);

  localparam int REM_W = $clog2(RUN_MAX + 1);

  typedef enum logic [1:0] {
    ST_OP    = 2'd0,
    ST_FULL2 = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               pix_valid_q, pix_valid_d;
  logic [11:0]        pix_data_q, pix_data_d;
  logic [11:0]        last_q, last_d;
  logic [15:0]        pix_count_q, pix_count_d;
  logic [6:0]         pal_cnt_q, pal_cnt_d;
  logic [3:0]         r_q, r_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [11:0]        pal_q [PAL_DEPTH];

  logic               out_free_s, accept_s, pix_fire_s;
  logic               load_s, pal_we_s;
  logic [11:0]        load_pix_s, diff_pix_s, idx_pix_s;
  logic [5:0]         pal_waddr_s;
`ifdef QOI444_DEC_IDX_CHECK_EN
  logic               err_q, err_d;
  logic               idx_bad_s;
`endif

  assign out_free_s  = !pix_valid_q || bus.pix_ready;
  // frame_start wins over traffic, so no byte may be handshaken in that cycle
  assign bus.in_ready = rst_n && !frame_start && out_free_s &&
                        ((state_q == ST_OP) || (state_q == ST_FULL2));
  assign accept_s    = bus.in_valid && bus.in_ready;
  assign pix_fire_s  = pix_valid_q && bus.pix_ready;
  assign pal_waddr_s = pal_cnt_q[5:0];
  assign idx_pix_s   = pal_q[bus.in_data[5:0]];
  assign diff_pix_s  = {last_q[11:8] - {2'b00, bus.in_data[5:4]} + 4'd2,
                        last_q[7:4]  - {2'b00, bus.in_data[3:2]} + 4'd2,
                        last_q[3:0]  - {2'b00, bus.in_data[1:0]} + 4'd2};
`ifdef QOI444_DEC_IDX_CHECK_EN
  assign idx_bad_s   = ({1'b0, bus.in_data[5:0]} >= pal_cnt_q);
`endif

  // Op decode, run expansion, output register and palette bookkeeping
  always_comb begin
    state_d     = state_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    last_d      = last_q;
    pix_count_d = pix_count_q;
    pal_cnt_d   = pal_cnt_q;
    r_d         = r_q;
    rem_d       = rem_q;
    load_s      = 1'b0;
    load_pix_s  = last_q;
    pal_we_s    = 1'b0;
`ifdef QOI444_DEC_IDX_CHECK_EN
    err_d       = err_q;
`endif
    if (!frame_start) begin
      case (state_q)
        ST_OP: begin
          if (accept_s) begin
            case (bus.in_data[7:6])
              2'b00: begin
                load_s = 1'b1;
`ifdef QOI444_DEC_IDX_CHECK_EN
                load_pix_s = idx_bad_s ? 12'h000 : idx_pix_s;
                err_d      = err_q | idx_bad_s;
`else
                load_pix_s = idx_pix_s;
`endif
              end
              2'b01: begin
                load_s     = 1'b1;
                load_pix_s = diff_pix_s;
              end
              2'b10: begin
                r_d     = bus.in_data[3:0];
                state_d = ST_FULL2;
              end
              2'b11: begin
                // RUN 0 is a no-op; RUN 1 needs no RUN state
                load_s = (bus.in_data[5:0] != 6'd0);
                if (bus.in_data[5:1] != 5'd0) begin
                  rem_d   = REM_W'(bus.in_data[5:0] - 6'd1);
                  state_d = ST_RUN;
                end else begin
                  state_d = ST_OP;
                end
              end
              default: state_d = ST_OP;
            endcase
          end else begin
            state_d = ST_OP;
          end
        end
        ST_FULL2: begin
          if (accept_s) begin
            load_s     = 1'b1;
            load_pix_s = {r_q, bus.in_data};
            pal_we_s   = (pal_cnt_q < 7'(PAL_DEPTH));
            pal_cnt_d  = pal_cnt_q + {6'd0, pal_we_s};
            state_d    = ST_OP;
          end else begin
            state_d = ST_FULL2;
          end
        end
        ST_RUN: begin
          if (pix_fire_s) begin
            load_s  = 1'b1;
            rem_d   = rem_q - REM_W'(1);
            state_d = (rem_q == REM_W'(1)) ? ST_OP : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_OP;
      endcase
      pix_valid_d = load_s | (pix_valid_q & ~pix_fire_s);
      pix_data_d  = load_s ? load_pix_s : pix_data_q;
      last_d      = load_s ? load_pix_s : last_q;
      pix_count_d = pix_count_q + {15'd0, pix_fire_s};
    end else begin
      state_d     = ST_OP;
      pix_valid_d = 1'b0;
      last_d      = 12'h000;
      pal_cnt_d   = 7'd0;
      rem_d       = '0;
      pix_count_d = 16'd0;
`ifdef QOI444_DEC_IDX_CHECK_EN
      err_d       = 1'b0;
`endif
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_OP;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 12'h000;
      last_q      <= 12'h000;
      pix_count_q <= 16'd0;
      pal_cnt_q   <= 7'd0;
      r_q         <= 4'd0;
      rem_q       <= '0;
`ifdef QOI444_DEC_IDX_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      last_q      <= last_d;
      pix_count_q <= pix_count_d;
      pal_cnt_q   <= pal_cnt_d;
      r_q         <= r_d;
      rem_q       <= rem_d;
`ifdef QOI444_DEC_IDX_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Palette storage is intentionally not reset; stale entries survive frames
  always_ff @(posedge clk) begin
    if (pal_we_s) begin
      pal_q[pal_waddr_s] <= {r_q, bus.in_data};
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign pix_count     = pix_count_q;
`ifdef QOI444_DEC_IDX_CHECK_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_qoi_rgb444_decoder.sv
// Scoreboard bench for qoi_rgb444_decoder: expected pixels are queued as bytes are
// driven and checked by a monitor on every pixel handshake.
module tb_qoi_rgb444_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] pix_count;
  logic        err;

  qoi_rgb444_decoder_if bus();

  qoi_rgb444_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bus         (bus.slave),
    .pix_count   (pix_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;
  int tests_run    = 0;
  int tests_failed = 0;

  // Pixel monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.pix_valid && bus.pix_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pixel_unexpected: got %h, required no pixel", bus.pix_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.pix_data !== mon_exp) begin
          tests_failed++;
          $display("FAIL pixel_data: got %h, required %h", bus.pix_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] col(input int i);
    col = 12'((i * 53 + 7) % 4096);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: byte %h not accepted, required acceptance within 200 cycles", b);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d pixels outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic check1(input string name, input logic [15:0] got, input logic [15:0] req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
    check1("reset_pix_data", {4'd0, bus.pix_data}, 16'h0000);
    check1("reset_in_ready", {15'd0, bus.in_ready}, 16'd0);
    check1("reset_pix_count", pix_count, 16'd0);
    check1("reset_err", {15'd0, err}, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("post_reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    pulse_frame_start();
    exp_q.push_back(12'hABC);
    send_byte(8'h8A);
    @(negedge clk);
    check1("full2_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
    check1("full2_in_ready", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk);
    #1;
    send_byte(8'hBC);
    drain("full");
    check1("full_pix_count", pix_count, 16'd1);
  endtask

  task automatic test_index_diff();
    exp_q.push_back(12'hABC);
    send_byte(8'h00);
    exp_q.push_back(12'hABC);
    send_byte(8'h6A);
    exp_q.push_back(12'hCDE);
    send_byte(8'h40);
    drain("index_diff");
  endtask

  task automatic test_run();
    logic [15:0] c0;
    c0 = pix_count;
    repeat (5) exp_q.push_back(12'hCDE);
    send_byte(8'hC5);
    @(negedge clk);
    check1("run_in_ready", {15'd0, bus.in_ready}, 16'd0);
    drain("run");
    check1("run_pix_count", pix_count, c0 + 16'd5);
    send_byte(8'hC0);
    repeat (5) @(negedge clk);
    check1("run0_pix_valid", {15'd0, bus.pix_valid}, 16'd0);
    check1("run0_pix_count", pix_count, c0 + 16'd5);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_backpressure();
    logic [15:0] c0;
    logic [11:0] held;
    c0 = pix_count;
    repeat (8) exp_q.push_back(12'hCDE);
    send_byte(8'hC8);
    @(posedge clk);
    #1;
    bus.pix_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h00;
    @(negedge clk);
    held = bus.pix_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("stall_pix_valid", {15'd0, bus.pix_valid}, 16'd1);
      check1("stall_pix_data", {4'd0, bus.pix_data}, {4'd0, held});
      check1("stall_in_ready", {15'd0, bus.in_ready}, 16'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.pix_ready = 1'b1;
    drain("backpressure");
    check1("backpressure_pix_count", pix_count, c0 + 16'd8);
  endtask

  task automatic test_palette_full();
    logic [11:0] c;
    pulse_frame_start();
    for (int i = 1; i <= 66; i++) begin
      c = col(i);
      exp_q.push_back(c);
      send_byte({4'b1000, c[11:8]});
      send_byte(c[7:0]);
    end
    exp_q.push_back(col(64));
    send_byte(8'h3F);
    exp_q.push_back(col(1));
    send_byte(8'h00);
    drain("palette");
  endtask

  task automatic test_frame_start();
    send_byte(8'h8A);
    pulse_frame_start();
    // last is 0 after frame_start, so DIFF d=0 gives 0x222 unless FULL2 survived
    exp_q.push_back(12'h222);
    send_byte(8'h40);
    drain("fs_full2");
    bus.pix_ready = 1'b0;
    send_byte(8'hFF);
    @(negedge clk);
    check1("fs_run_pending", {15'd0, bus.pix_valid}, 16'd1);
    pulse_frame_start();
    @(negedge clk);
    check1("fs_run_dropped", {15'd0, bus.pix_valid}, 16'd0);
    @(posedge clk);
    #1 bus.pix_ready = 1'b1;
    repeat (5) @(negedge clk);
    check1("fs_run_no_pixel", {15'd0, bus.pix_valid}, 16'd0);
    @(posedge clk);
    #1;
`ifdef QOI444_DEC_IDX_CHECK_EN
    exp_q.push_back(12'h000);
    send_byte(8'h03);
    drain("fs_idx_bad");
    check1("fs_err", {15'd0, err}, 16'd1);
`else
    exp_q.push_back(col(4));
    send_byte(8'h03);
    drain("fs_idx_stale");
    check1("fs_err", {15'd0, err}, 16'd0);
`endif
    exp_q.push_back(12'h123);
    send_byte(8'h81);
    send_byte(8'h23);
    exp_q.push_back(12'h123);
    send_byte(8'h00);
    drain("fs_pal_restart");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.pix_ready = 1'b1;
    test_reset();
    test_full();
    test_index_diff();
    test_run();
    test_back_to_back_backpressure();
    test_palette_full();
    test_frame_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
